// File: rtl/mult_iter_64.sv
// Iterative radix-2 shift-add multiplier for MUL/SMULH/UMULH.
// Works on operand magnitudes, then applies the sign once at the end.
module mult_iter_64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prodLo,
  output logic [WIDTH-1:0] prodHi
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplier;   // multiplier; low product half shifts in from the top
  logic             neg;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc, acc_fix;

  // Most-negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
  assign mag_a   = (is_signed && opA[WIDTH-1]) ? -opA : opA;
  assign mag_b   = (is_signed && opB[WIDTH-1]) ? -opB : opB;
  assign sum     = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign acc     = {acc_hi, mplier};
  assign acc_fix = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      prodLo <= '0;
      prodHi <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc_hi <= '0;
            neg    <= is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Carry out of the add becomes the new top bit after the shift.
          acc_hi <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          {prodHi, prodLo} <= acc_fix;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
